// File: rtl/calc_op_sequencer.sv
// Key-to-command sequencer between the numpad decoder and the RPN operand stack.
// Each accepted key yields one registered command; division runs a multi-cycle restoring divider.
//
// state    | meaning
// IDLE     | waiting for a new key
// ISSUE    | one-cycle command pulse on the outputs
// DIV_RUN  | restoring divider iterating, one quotient bit per cycle
// DIV_DONE | sign-correct quotient, issue pop+write
module calc_op_sequencer #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [4:0]         key,
    input  logic [WIDTH-1:0]   top,
    input  logic [WIDTH-1:0]   next,
    input  logic [COUNT_W-1:0] count,
    output logic               write,
    output logic               push,
    output logic               pop,
    output logic [WIDTH-1:0]   new_value,
    output logic               busy,
    output logic               div_zero,
    output logic               op_error
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        DIV_RUN  = 2'd2,
        DIV_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         prev_key_q, prev_key_d;
    logic               write_q, write_d;
    logic               push_q, push_d;
    logic               pop_q, pop_d;
    logic [WIDTH-1:0]   new_value_q, new_value_d;
    logic               busy_q, busy_d;
    logic               div_zero_q, div_zero_d;
    logic               op_error_q, op_error_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               sign_q, sign_d;

    logic               accept;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   abs_top;
    logic [WIDTH-1:0]   abs_next;
    logic [3:0]         digit;

    function automatic logic [3:0] digit_of(input logic [3:0] code);
        logic [3:0] d;
        case (code)
            4'b0000: d = 4'd1;
            4'b0001: d = 4'd4;
            4'b0010: d = 4'd7;
            4'b0011: d = 4'd0;
            4'b0100: d = 4'd2;
            4'b0101: d = 4'd5;
            4'b0110: d = 4'd8;
            4'b1000: d = 4'd3;
            4'b1001: d = 4'd6;
            4'b1010: d = 4'd9;
            default: d = 4'd0;
        endcase
        return d;
    endfunction

    always_comb begin
        accept   = key[4] && (key != prev_key_q);
        abs_top  = top[WIDTH-1]  ? -top  : top;
        abs_next = next[WIDTH-1] ? -next : next;
        digit    = digit_of(key[3:0]);
        // Shift in the next dividend bit and try to subtract the divisor.
        trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

        state_d     = state_q;
        prev_key_d  = key;
        write_d     = 1'b0;
        push_d      = 1'b0;
        pop_d       = 1'b0;
        op_error_d  = 1'b0;
        new_value_d = new_value_q;
        busy_d      = busy_q;
        div_zero_d  = div_zero_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        sign_d      = sign_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    div_zero_d = 1'b0;
                    state_d    = ISSUE;
                    case (key[3:0])
                        4'b1100: push_d = 1'b1;
                        4'b0111: begin
                            write_d     = 1'b1;
                            new_value_d = -top;
                        end
                        4'b1101, 4'b1110, 4'b1111: begin
                            if (count < COUNT_W'(2)) begin
                                op_error_d = 1'b1;
                            end else begin
                                pop_d   = 1'b1;
                                write_d = 1'b1;
                                case (key[1:0])
                                    2'b01:   new_value_d = next + top;
                                    2'b10:   new_value_d = next - top;
                                    default: new_value_d = next * top;
                                endcase
                            end
                        end
                        4'b1011: begin
                            if (count < COUNT_W'(2)) begin
                                op_error_d = 1'b1;
                            end else if (top == '0) begin
                                div_zero_d = 1'b1;
                                state_d    = IDLE;
                            end else begin
                                quo_d   = abs_next;
                                dvs_d   = abs_top;
                                rem_d   = '0;
                                cnt_d   = '0;
                                sign_d  = next[WIDTH-1] ^ top[WIDTH-1];
                                busy_d  = 1'b1;
                                state_d = DIV_RUN;
                            end
                        end
                        default: begin
                            write_d     = 1'b1;
                            new_value_d = top * WIDTH'(10) + {{(WIDTH-4){1'b0}}, digit};
                        end
                    endcase
                end
            end
            ISSUE: state_d = IDLE;
            DIV_RUN: begin
                if (trial[WIDTH]) begin
                    rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                end else begin
                    rem_d = trial[WIDTH-1:0];
                end
                quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                pop_d       = 1'b1;
                write_d     = 1'b1;
                new_value_d = sign_q ? -quo_q : quo_q;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            prev_key_q  <= 5'b00000;
            write_q     <= 1'b0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            new_value_q <= '0;
            busy_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            op_error_q  <= 1'b0;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            sign_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_key_q  <= prev_key_d;
            write_q     <= write_d;
            push_q      <= push_d;
            pop_q       <= pop_d;
            new_value_q <= new_value_d;
            busy_q      <= busy_d;
            div_zero_q  <= div_zero_d;
            op_error_q  <= op_error_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            sign_q      <= sign_d;
        end
    end

    assign write     = write_q;
    assign push      = push_q;
    assign pop       = pop_q;
    assign new_value = new_value_q;
    assign busy      = busy_q;
    assign div_zero  = div_zero_q;
    assign op_error  = op_error_q;

endmodule
